// File: rtl/merge_pkg.sv
// Shared constants and FSM state encoding for the merge core host driver.
package merge_pkg;

  // Word width of the merge core data path.
  localparam int DATA_W = 32;

  // Per-run capacity of the merge core input FIFOs.
  localparam int FIFO_DEPTH = 512;

  // Driver FSM states.
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LOAD_A  = 3'd1;
  localparam state_t S_LOAD_B  = 3'd2;
  localparam state_t S_SETTLE  = 3'd3;
  localparam state_t S_RUN     = 3'd4;
  localparam state_t S_DRAIN   = 3'd5;
  localparam state_t S_RELEASE = 3'd6;

endpackage

// File: rtl/merge_drain_buf.sv
// Single-entry output register that pulls merged words from the core's
// first-word-fall-through FIFO and presents them on a valid/ready stream.
module merge_drain_buf #(
  parameter int DATA_W = merge_pkg::DATA_W,
  parameter int CNT_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [CNT_W-1:0]  total,
  input  logic              active,
  input  logic [DATA_W-1:0] core_rd_data,
  output logic              core_rd_en,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              finished
);

  logic [CNT_W-1:0] remaining;

  // Read only while words remain and the register is empty or being consumed.
  assign core_rd_en = active && (remaining != '0) && (!out_valid || out_ready);
  // Done once every word is read and the register is empty or draining now.
  assign finished   = active && (remaining == '0) && (!out_valid || out_ready);

  // Remaining-word counter and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (load) begin
        remaining <= total;
      end else if (core_rd_en) begin
        remaining <= remaining - 1'b1;
      end
      if (core_rd_en) begin
        out_data  <= core_rd_data;
        out_valid <= 1'b1;
        out_last  <= (remaining == CNT_W'(1));
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/merge_driver.sv
// Host-side initiator for one mergeCore: loads two runs into the core FIFOs,
// runs the start/done handshake and drains the merged stream downstream.
//
// Handshakes: every valid/ready pair transfers exactly one item on a rising
// clock edge where both are high; valid never depends on ready, and a
// producer holds valid and data stable until the transfer happens.
module merge_driver
  import merge_pkg::*;
#(
  parameter int DATA_W        = merge_pkg::DATA_W,
  parameter int LEN_W         = 10,
  parameter int FIFO_DEPTH    = merge_pkg::FIFO_DEPTH,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 65535
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [LEN_W-1:0]  cfg_len_a,
  input  logic [LEN_W-1:0]  cfg_len_b,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] core_wr_data,
  output logic              core_fifo1_wr_en,
  output logic              core_fifo2_wr_en,
  output logic              core_start,
  input  logic              core_done,
  output logic              core_rd_en,
  input  logic [DATA_W-1:0] core_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              job_done,
  output logic              err,
  output logic [2:0]        fsm_state
);

  // One timer serves both the settle delay and the done timeout; SETTLE_CYCLES >= 1.
  localparam int TIMER_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  state_t             state;
  logic [LEN_W-1:0]   len_b_q;
  logic [LEN_W-1:0]   count;
  logic [LEN_W:0]     total;
  logic [TIMER_W-1:0] timer;
  logic               too_long;
  logic               wr_any;
  logic               drain_load;
  logic               drain_finished;

  assign fsm_state  = state;
  assign cfg_ready  = (state == S_IDLE) && !reset;
  assign in_ready   = (state == S_LOAD_A) || (state == S_LOAD_B);
  // Start stays high from RUN through DRAIN and drops on entry to RELEASE.
  assign core_start = (state == S_RUN) || (state == S_DRAIN);
  assign wr_any     = core_fifo1_wr_en || core_fifo2_wr_en;
  assign too_long   = ({1'b0, cfg_len_a} > (LEN_W+1)'(FIFO_DEPTH)) ||
                      ({1'b0, cfg_len_b} > (LEN_W+1)'(FIFO_DEPTH));
  assign drain_load = (state == S_RUN) && core_done;

  // Job sequencing FSM with FIFO write staging, timers and error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      len_b_q          <= '0;
      count            <= '0;
      total            <= '0;
      timer            <= '0;
      core_wr_data     <= '0;
      core_fifo1_wr_en <= 1'b0;
      core_fifo2_wr_en <= 1'b0;
      job_done         <= 1'b0;
      err              <= 1'b0;
    end else begin
      core_fifo1_wr_en <= 1'b0;
      core_fifo2_wr_en <= 1'b0;
      job_done         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cfg_valid) begin
            err     <= 1'b0;
            len_b_q <= cfg_len_b;
            total   <= {1'b0, cfg_len_a} + {1'b0, cfg_len_b};
            timer   <= '0;
            if (too_long) begin
              err      <= 1'b1;
              job_done <= 1'b1;
            end else if (cfg_len_a != '0) begin
              state <= S_LOAD_A;
              count <= cfg_len_a;
            end else if (cfg_len_b != '0) begin
              state <= S_LOAD_B;
              count <= cfg_len_b;
            end else begin
              state <= S_SETTLE;
            end
          end
        end
        S_LOAD_A: begin
          if (in_valid) begin
            core_wr_data     <= in_data;
            core_fifo1_wr_en <= 1'b1;
            count            <= count - 1'b1;
            if (count == LEN_W'(1)) begin
              if (len_b_q != '0) begin
                state <= S_LOAD_B;
                count <= len_b_q;
              end else begin
                state <= S_SETTLE;
              end
            end
          end
        end
        S_LOAD_B: begin
          if (in_valid) begin
            core_wr_data     <= in_data;
            core_fifo2_wr_en <= 1'b1;
            count            <= count - 1'b1;
            if (count == LEN_W'(1)) begin
              state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          // The count restarts while the final write is still on the bus.
          if (wr_any) begin
            timer <= '0;
          end else if (timer == TIMER_W'(SETTLE_CYCLES - 1)) begin
            timer <= '0;
            state <= S_RUN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RUN: begin
          if (core_done) begin
            state <= S_DRAIN;
          end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= S_RELEASE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_finished) begin
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!core_done) begin
            job_done <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  merge_drain_buf #(
    .DATA_W (DATA_W),
    .CNT_W  (LEN_W + 1)
  ) u_drain (
    .clock        (clock),
    .reset        (reset),
    .load         (drain_load),
    .total        (total),
    .active       (state == S_DRAIN),
    .core_rd_data (core_rd_data),
    .core_rd_en   (core_rd_en),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .finished     (drain_finished)
  );

endmodule

// File: tb/tb_merge_driver.sv
// Bench for merge_driver: behavioural mergeCore model, job driver and
// scoreboard of expected merged words.
module tb_merge_driver;
  import merge_pkg::*;

  localparam int DW     = 32;
  localparam int LW     = 10;
  localparam int DEPTH  = FIFO_DEPTH;
  localparam int SETTLE = 4;
  localparam int TMO    = 20;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          cfg_valid = 1'b0, cfg_ready;
  logic [LW-1:0] cfg_len_a = '0, cfg_len_b = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] core_wr_data;
  logic          wr1, wr2, core_start, core_rd_en;
  logic          core_done = 1'b0;
  logic [DW-1:0] core_rd_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, job_done, err;
  logic          out_ready = 1'b0;
  logic [2:0]    dbg_state;

  merge_driver #(
    .DATA_W(DW), .LEN_W(LW), .FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len_a(cfg_len_a), .cfg_len_b(cfg_len_b),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_wr_data(core_wr_data), .core_fifo1_wr_en(wr1), .core_fifo2_wr_en(wr2),
    .core_start(core_start), .core_done(core_done),
    .core_rd_en(core_rd_en), .core_rd_data(core_rd_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .job_done(job_done), .err(err), .fsm_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- model state ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] fifo1_q[$], fifo2_q[$], core_q[$];
  logic [DW-1:0] run_a[$], run_b[$];
  int   cyc = 0;
  int   wr1_cnt, wr2_cnt, rd_cnt, jd_cnt, start_cnt, out_cnt;
  int   both_wr = 0, stall_err = 0;
  int   last_wr_cyc, start_rise_cyc;
  logic start_prev = 1'b0, hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic s_start = 1'b0, s_rd = 1'b0, s_reset = 1'b1;
  logic core_hang = 1'b0;
  int   ready_mode = 0;

  // Monitor: observe DUT outputs mid-cycle and score the output stream.
  always @(negedge clock) begin
    logic [DW-1:0] e;
    cyc++;
    s_reset = reset;
    s_start = core_start && !reset;
    s_rd    = core_rd_en && !reset;
    if (reset) begin
      start_prev   = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (wr1 && wr2) both_wr++;
      if (wr1) begin fifo1_q.push_back(core_wr_data); wr1_cnt++; last_wr_cyc = cyc; end
      if (wr2) begin fifo2_q.push_back(core_wr_data); wr2_cnt++; last_wr_cyc = cyc; end
      if (core_rd_en) rd_cnt++;
      if (job_done) jd_cnt++;
      if (core_start) start_cnt++;
      if (core_start && !start_prev) start_rise_cyc = cyc;
      start_prev = core_start;
      if (hold_pending && (!out_valid || out_data !== hold_data)) stall_err++;
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_data", out_data, e);
          check("out_last", out_last, exp_q.size() == 0);
        end
      end
    end
  end

  // mergeCore model: collects FIFO writes, merges on start, serves FWFT reads.
  initial begin
    int phase = 0;
    int delay = 0;
    forever begin
      @(posedge clock); #1;
      if (s_reset) begin
        phase = 0;
        core_done = 1'b0;
        core_q.delete();
      end else begin
        if (s_rd && core_q.size() > 0) void'(core_q.pop_front());
        case (phase)
          0: if (s_start) begin
               if (core_hang) phase = 2;
               else begin delay = $urandom_range(1, 8); phase = 1; end
             end
          1: begin
               delay--;
               if (delay == 0) begin
                 while (fifo1_q.size() > 0 || fifo2_q.size() > 0) begin
                   if (fifo2_q.size() == 0 || (fifo1_q.size() > 0 && fifo1_q[0] <= fifo2_q[0]))
                     core_q.push_back(fifo1_q.pop_front());
                   else
                     core_q.push_back(fifo2_q.pop_front());
                 end
                 core_done = 1'b1;
                 phase = 2;
               end
             end
          default: if (!s_start) begin core_done = 1'b0; phase = 0; end
        endcase
      end
      core_rd_data = (core_q.size() > 0) ? core_q[0] : '0;
    end
  end

  // Downstream ready pattern: 0 always ready, 1 random, 2 repeating 1,0,0,1.
  initial begin
    int pc = 0;
    logic [3:0] pat = 4'b1001;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: begin out_ready = pat[pc % 4]; pc++; end
      endcase
    end
  end

  // ---------------- driver ----------------
  task automatic run_job(input int la, input int lb, input bit hang, input int rmode,
                         input int abort_at);
    int  total = la + lb;
    bit  bad   = (la > DEPTH) || (lb > DEPTH);
    int  k;
    logic [DW-1:0] w;
    exp_q.delete(); fifo1_q.delete(); fifo2_q.delete();
    wr1_cnt = 0; wr2_cnt = 0; rd_cnt = 0; jd_cnt = 0; start_cnt = 0; out_cnt = 0;
    last_wr_cyc = -1; start_rise_cyc = -1;
    core_hang = hang; ready_mode = rmode;
    // Reference: one empty run passes through in order; otherwise sorted union.
    if (!bad && !hang && abort_at < 0) begin
      foreach (run_a[i]) exp_q.push_back(run_a[i]);
      foreach (run_b[i]) exp_q.push_back(run_b[i]);
      if (la > 0 && lb > 0) exp_q.sort();
    end
    @(posedge clock); #1;
    in_valid = 1'b0; cfg_valid = 1'b1; cfg_len_a = LW'(la); cfg_len_b = LW'(lb);
    k = 0;
    do begin @(negedge clock); k++; end while (!cfg_ready && k < 100);
    check("cfg_ready", cfg_ready, 1);
    @(posedge clock); #1;
    cfg_valid = 1'b0; cfg_len_a = LW'($urandom); cfg_len_b = LW'($urandom);
    @(negedge clock);
    check("err_after_accept", err, bad);
    @(posedge clock); #1;
    for (int i = 0; i < total && !bad; i++) begin
      if (i == abort_at) begin
        reset = 1'b1; in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("reset_ctrl", {cfg_ready, in_ready, wr1, wr2, core_start, core_rd_en,
                             out_valid, out_last, job_done, err}, 10'b0);
        check("reset_data", {core_wr_data, out_data}, 64'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete(); fifo1_q.delete(); fifo2_q.delete();
        repeat (2) @(negedge clock);
        check("idle_after_reset", {cfg_ready, in_ready, core_start}, 3'b100);
        return;
      end
      w = (i < la) ? run_a[i] : run_b[i - la];
      if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge clock); #1; end
      in_valid = 1'b1; in_data = w;
      k = 0;
      do begin @(negedge clock); k++; end while (!in_ready && k < 100);
      check("in_ready", in_ready, 1);
      @(posedge clock); #1;
    end
    // Words offered outside the load states must be ignored.
    in_valid = 1'b1; in_data = $urandom;
    k = 0;
    while (jd_cnt == 0 && k < 3000) begin @(negedge clock); k++; end
    check("job_done_seen", jd_cnt > 0, 1);
    repeat (3) @(negedge clock);
    in_valid = 1'b0;
    check("job_done_once", jd_cnt, 1);
    check("err", err, bad || hang);
    check("fifo1_writes", wr1_cnt, bad ? 0 : la);
    check("fifo2_writes", wr2_cnt, bad ? 0 : lb);
    check("out_count", out_cnt, (bad || hang) ? 0 : total);
    check("rd_en_count", rd_cnt, (bad || hang) ? 0 : total);
    check("exp_left", exp_q.size(), 0);
    check("cfg_ready_idle", cfg_ready, 1);
    if (!bad) check("start_seen", start_rise_cyc >= 0, 1);
    if (!bad && total > 0) check("settle_gap", start_rise_cyc - last_wr_cyc, SETTLE + 1);
    if (hang) check("run_cycles", start_cnt, TMO);
  endtask

  task automatic make_runs(input int la, input int lb);
    int v;
    run_a.delete(); run_b.delete();
    v = $urandom_range(0, 1000);
    for (int i = 0; i < la; i++) begin v += $urandom_range(0, 20); run_a.push_back(DW'(v)); end
    v = $urandom_range(0, 1000);
    for (int i = 0; i < lb; i++) begin v += $urandom_range(0, 20); run_b.push_back(DW'(v)); end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_ctrl_init", {cfg_ready, in_ready, wr1, wr2, core_start, core_rd_en,
                              out_valid, out_last, job_done, err}, 10'b1000000000);
    check("reset_data_init", {core_wr_data, out_data}, 64'b0);

    run_a = '{1, 5, 9};     run_b = '{2, 6, 7};  run_job(3, 3, 0, 0, -1);
    run_a = '{8, 3, 4, 10}; run_b.delete();      run_job(4, 0, 0, 0, -1);
    run_a.delete();         run_b.delete();      run_job(0, 0, 0, 0, -1);
    run_a = '{1, 5, 9};     run_b = '{2, 6, 7};  run_job(3, 3, 0, 2, -1);
    make_runs(2, 1);                             run_job(2, 1, 1, 0, -1);
    make_runs(3, 2);                             run_job(3, 2, 0, 1, -1);
    run_a.delete();         run_b.delete();      run_job(DEPTH + 1, 1, 0, 0, -1);
    make_runs(2, 2);                             run_job(2, 2, 0, 0, -1);
    make_runs(0, 5);                             run_job(0, 5, 0, 1, -1);
    make_runs(2, 4);                             run_job(2, 4, 0, 0, 4);
    make_runs(DEPTH, 0);                         run_job(DEPTH, 0, 0, 0, -1);
    for (int j = 0; j < 12; j++) begin
      int la = $urandom_range(0, 10);
      int lb = $urandom_range(0, 10);
      make_runs(la, lb);
      run_job(la, lb, 0, $urandom_range(0, 2), -1);
    end
    check("wr_exclusive", both_wr, 0);
    check("stall_hold", stall_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends with a summary.
  initial begin
    #1000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_driver.md
Name: merge_driver

Overview:
- Initiator for the merge core's host-side interface.
- Accepts a job descriptor (two run lengths) and a word stream, then loads the first len_a words into FIFO1 and the next len_b words into FIFO2.
- Runs the start/done handshake, drains len_a+len_b merged words to an output valid/ready stream, and releases the core for the next job.
- Sits between the DMA/AXI-stream shim and one mergeCore instance; shares that instance's clock and reset.

Parameters:
DATA_W, 32, word width; must equal the merge core data width.
LEN_W, 10, run-length field width.
FIFO_DEPTH, 512, per-run capacity of the merge core input FIFOs.
SETTLE_CYCLES, 4, idle cycles after the last FIFO write before start rises; covers FIFO empty-flag latency.
TIMEOUT, 65535, maximum cycles to wait for core_done.

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  descriptor accepted when cfg_valid & cfg_ready
cfg_len_a  in  LEN_W  words destined for FIFO1
cfg_len_b  in  LEN_W  words destined for FIFO2
in_data  in  DATA_W  input word
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid & in_ready
core_wr_data  out  DATA_W  to mergeCore fifoWrData
core_fifo1_wr_en  out  1  to mergeCore fifo1WrEn
core_fifo2_wr_en  out  1  to mergeCore fifo2WrEn
core_start  out  1  to mergeCore start
core_done  in  1  from mergeCore done
core_rd_en  out  1  to mergeCore mergedFifoRdEn
core_rd_data  in  DATA_W  from mergeCore mergedFifoRdData (first-word-fall-through)
out_data  out  DATA_W  merged word
out_valid  out  1  merged word valid
out_ready  in  1  downstream ready
out_last  out  1  marks the final word of a job
job_done  out  1  one-cycle pulse at job completion
err  out  1  sticky error flag; cleared on next accepted descriptor

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-job abandons the job; the core is reset by the same signal, so no cleanup is required.
- IDLE:
  - cfg_ready=1.
  - On accept: latch the lengths, clear err.
  - If len_a>FIFO_DEPTH or len_b>FIFO_DEPTH: set err, pulse job_done next cycle, stay IDLE.
  - Otherwise go to LOAD_A; skip to LOAD_B if len_a=0, and to SETTLE if both are 0.
- LOAD_A:
  - in_ready=1.
  - Each accepted word is registered onto core_wr_data with core_fifo1_wr_en=1 the next cycle, one write per accepted word, and the remaining count decrements.
  - On the last word go to LOAD_B, or to SETTLE if len_b=0.
- LOAD_B: identical to LOAD_A, using core_fifo2_wr_en; on the last word go to SETTLE.
- Write enables are never both high. in_ready=0 in every state except LOAD_A and LOAD_B.
- SETTLE: count SETTLE_CYCLES cycles after the final write enable deasserts, then go to RUN.
- RUN:
  - core_start=1, held continuously until RELEASE.
  - Timeout counter runs; when core_done=1, go to DRAIN.
  - If the counter reaches TIMEOUT: set err, drop start, go to RELEASE without draining.
- DRAIN:
  - remaining = len_a+len_b, LEN_W+1 bits wide.
  - core_rd_en = (remaining>0) & (!out_valid | out_ready).
  - On core_rd_en: out_data<=core_rd_data, out_valid<=1, remaining decrements; out_last<=1 when remaining==1.
  - out_valid clears on out_ready when no new read occurs.
  - Throughput is 1 word/cycle under continuous out_ready. Output is stable while out_valid & !out_ready.
  - Exit to RELEASE when remaining==0 and the output register is empty or its last word is being consumed.
  - A zero-word job emits nothing and has no out_last.
- RELEASE: core_start=0; wait for core_done=0, then pulse job_done and go to IDLE.
- Simultaneous events:
  - In_valid outside a load state is ignored.
  - A descriptor is never accepted outside IDLE.

Decomposition:
- Package merge_pkg holds: DATA_W, the state enumeration (IDLE, LOAD_A, LOAD_B, SETTLE, RUN, DRAIN, RELEASE), and the FIFO_DEPTH default shared with mergeCore.
- One sub-module, merge_drain_buf, implements the single-entry output register with its read-enable logic.

Test Plan:
- len_a=3 {1,5,9}, len_b=3 {2,6,7}, out_ready=1 -> out 1,2,5,6,7,9; out_last on 9; job_done once; err=0.
- len_a=4, len_b=0 {8,3,4,10} -> FIFO2 never written; out 8,3,4,10 in FIFO1 order; out_last on 10.
- len_a=0, len_b=0 -> start handshake completes, no out_valid, job_done pulse, back to IDLE.
- Drain with out_ready toggling 1,0,0,1 -> out_data held while stalled; no word dropped or duplicated; core_rd_en count equals 6.
- core_done tied 0, TIMEOUT=20 -> err=1 after 20 RUN cycles; start drops; job_done pulse; next valid descriptor clears err.
- cfg_len_a=FIFO_DEPTH+1 -> descriptor accepted, err=1, no core writes; reset asserted mid-LOAD_B -> all outputs 0 the next cycle.
